// File: rtl/edge_cycle_tracker_if.sv
// Bus between the edge tracker and its environment: the tracked signal,
// control levels, and the registered edge/marker/status outputs.
interface edge_cycle_tracker_if #(
    parameter int unsigned CNT_W = 8
);
    logic             sig_in;
    logic             enable;
    logic             clear;
    logic             edge_pulse;
    logic             plus_pulse;
    logic             minus_pulse;
    logic [CNT_W-1:0] cyc_count;
    logic             done;
    logic             timeout_err;
    logic [1:0]       state;

    modport master (
        output sig_in, enable, clear,
        input  edge_pulse, plus_pulse, minus_pulse, cyc_count, done, timeout_err, state
    );

    modport slave (
        input  sig_in, enable, clear,
        output edge_pulse, plus_pulse, minus_pulse, cyc_count, done, timeout_err, state
    );
endinterface

// File: rtl/edge_cycle_tracker.sv
// Tracks rising edges of an asynchronous toggling signal: resynchronises it,
// counts edges with even/odd markers, flags LIMIT overrun and stalls.
module edge_cycle_tracker #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned LIMIT   = 20,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    edge_cycle_tracker_if.slave bus
);

    localparam int unsigned        WDOG_W    = 16;
    localparam logic [CNT_W-1:0]   LIMIT_V   = CNT_W'(LIMIT);
    localparam logic [WDOG_W-1:0]  WDOG_LAST = WDOG_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                sync0_q, sync1_q, prev_q;
    logic                rise_c;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic                done_q, done_d;
    logic                terr_q, terr_d;
    logic                plus_q, plus_d;
    logic                minus_q, minus_d;
    logic                edge_q;

    // Two-flop synchroniser plus history flop for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync0_q <= 1'b0;
            sync1_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync0_q <= bus.sig_in;
            sync1_q <= sync0_q;
            prev_q  <= sync1_q;
        end
    end

    assign rise_c = sync1_q & ~prev_q;

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            wdog_q  <= '0;
            done_q  <= 1'b0;
            terr_q  <= 1'b0;
            plus_q  <= 1'b0;
            minus_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            wdog_q  <= wdog_d;
            done_q  <= done_d;
            terr_q  <= terr_d;
            plus_q  <= plus_d;
            minus_q <= minus_d;
            edge_q  <= rise_c;
        end
    end

    // Next-state logic; clear beats pause, pause beats a rise, a rise beats expiry.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        wdog_d  = wdog_q;
        done_d  = done_q;
        terr_d  = terr_q;
        plus_d  = 1'b0;
        minus_d = 1'b0;

        if (bus.clear) begin
            state_d = IDLE;
            count_d = '0;
            wdog_d  = '0;
            done_d  = 1'b0;
            terr_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    wdog_d = '0;
                    if (bus.enable) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (!bus.enable) begin
                        state_d = IDLE;
                        wdog_d  = '0;
                    end else if (rise_c) begin
                        count_d = count_q + CNT_W'(1);
                        wdog_d  = '0;
                        plus_d  = ~count_d[0];
                        minus_d = count_d[0];
                        if (count_d > LIMIT_V) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end
                    end else if (wdog_q == WDOG_LAST) begin
                        state_d = ERR;
                        terr_d  = 1'b1;
                        wdog_d  = '0;
                    end else begin
                        wdog_d = wdog_q + WDOG_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.edge_pulse  = edge_q;
    assign bus.plus_pulse  = plus_q;
    assign bus.minus_pulse = minus_q;
    assign bus.cyc_count   = count_q;
    assign bus.done        = done_q;
    assign bus.timeout_err = terr_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_edge_cycle_tracker.sv
// Self-checking bench for edge_cycle_tracker: directed scenarios plus
// randomized traffic, every cycle compared with a behavioural model.
module tb_edge_cycle_tracker;

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned LIMIT   = 20;
    localparam int unsigned TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst;

    edge_cycle_tracker_if #(.CNT_W(CNT_W)) bus ();

    edge_cycle_tracker #(
        .CNT_W   (CNT_W),
        .LIMIT   (LIMIT),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int seen_edge, seen_plus, seen_minus;

    // Reference model: mode 0..3 = IDLE/RUN/DONE/ERR; a counted rise is one
    // whose input was sampled high two edges ago after being low three ago.
    int m_cyc, m_anchor, m_count, m_mode;
    bit m_done, m_terr, e_edge, e_plus, e_minus;
    bit smp[$];

    always @(posedge clk or posedge rst) begin : ref_model
        bit rise;
        if (rst) begin
            m_cyc = 0; m_anchor = 0; m_count = 0; m_mode = 0;
            m_done = 0; m_terr = 0; e_edge = 0; e_plus = 0; e_minus = 0;
            smp = '{1'b0, 1'b0, 1'b0};
        end else begin
            rise = smp[1] && !smp[2];
            smp.push_front(bus.sig_in);
            void'(smp.pop_back());
            m_cyc++;
            e_edge = rise; e_plus = 0; e_minus = 0;
            if (bus.clear) begin
                m_mode = 0; m_count = 0; m_done = 0; m_terr = 0;
            end else if (m_mode == 0) begin
                if (bus.enable) begin m_mode = 1; m_anchor = m_cyc; end
            end else if (m_mode == 1) begin
                if (!bus.enable) m_mode = 0;
                else if (rise) begin
                    m_count++;
                    m_anchor = m_cyc;
                    if (m_count % 2 == 0) e_plus = 1; else e_minus = 1;
                    if (m_count > int'(LIMIT)) begin m_mode = 2; m_done = 1; end
                end else if (m_cyc - m_anchor >= int'(TIMEOUT)) begin
                    m_mode = 3; m_terr = 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic chk_all();
        chk("edge_pulse",  int'(bus.edge_pulse),  int'(e_edge));
        chk("plus_pulse",  int'(bus.plus_pulse),  int'(e_plus));
        chk("minus_pulse", int'(bus.minus_pulse), int'(e_minus));
        chk("cyc_count",   int'(bus.cyc_count),   m_count);
        chk("done",        int'(bus.done),        int'(m_done));
        chk("timeout_err", int'(bus.timeout_err), int'(m_terr));
        chk("state",       int'(bus.state),       m_mode);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        seen_edge  += int'(bus.edge_pulse);
        seen_plus  += int'(bus.plus_pulse);
        seen_minus += int'(bus.minus_pulse);
        chk_all();
    endtask

    task automatic pulse(input int hi, input int lo);
        bus.sig_in = 1'b1;
        repeat (hi) tick();
        bus.sig_in = 1'b0;
        repeat (lo) tick();
    endtask

    task automatic clear_seen();
        seen_edge = 0; seen_plus = 0; seen_minus = 0;
    endtask

    initial begin : global_bound
        #400000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "bench exceeded time bound");
    end

    initial begin : stimulus
        int n;
        bit stall;
        rst = 1'b1;
        bus.sig_in = 1'b0; bus.enable = 1'b0; bus.clear = 1'b0;
        clear_seen();
        repeat (3) tick();
        chk("reset_state", int'(bus.state), 0);
        chk("reset_count", int'(bus.cyc_count), 0);

        // Basic count: toggle every 10 clk with enable from reset release.
        bus.enable = 1'b1;
        rst = 1'b0;
        clear_seen();
        for (int i = 0; i < 430; i++) begin
            bus.sig_in = ((i / 10) % 2) == 0;
            tick();
        end
        chk("basic_count", int'(bus.cyc_count), 21);
        chk("basic_done",  int'(bus.done), 1);
        chk("basic_state", int'(bus.state), 2);
        chk("basic_edges", seen_edge, 22);
        chk("basic_minus", seen_minus, 11);
        chk("basic_plus",  seen_plus, 10);

        // Watchdog: hold sig_in low and time RUN entry to ERR.
        bus.sig_in = 1'b0; bus.enable = 1'b0; bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        repeat (4) tick();
        bus.enable = 1'b1;
        n = 0;
        while (bus.state != 2'd1 && n < 10) begin tick(); n++; end
        chk("wdog_run_entry", n, 1);
        n = 0;
        while (bus.state != 2'd3 && n < 200) begin tick(); n++; end
        chk("wdog_cycles", n, int'(TIMEOUT));
        chk("wdog_err", int'(bus.timeout_err), 1);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        chk("wdog_clear_state", int'(bus.state), 0);
        chk("wdog_clear_err", int'(bus.timeout_err), 0);
        chk("wdog_clear_count", int'(bus.cyc_count), 0);

        // Pause: 5 rises, 3 rises with enable low, then one more counted.
        tick();
        for (int i = 0; i < 5; i++) pulse($urandom_range(3, 6), $urandom_range(3, 6));
        chk("pause_pre", int'(bus.cyc_count), 5);
        bus.enable = 1'b0;
        clear_seen();
        for (int i = 0; i < 3; i++) pulse($urandom_range(3, 6), $urandom_range(3, 6));
        chk("pause_hold", int'(bus.cyc_count), 5);
        chk("pause_edges", seen_edge, 3);
        bus.enable = 1'b1;
        tick();
        clear_seen();
        pulse(4, 4);
        chk("pause_resume", int'(bus.cyc_count), 6);
        chk("pause_plus", seen_plus, 1);
        chk("pause_minus", seen_minus, 0);

        // Rise coinciding with watchdog expiry is counted.
        for (int k = 0; k < 200 && m_cyc != m_anchor + 61; k++) tick();
        bus.sig_in = 1'b1;
        repeat (3) tick();
        chk("coincide_state", int'(bus.state), 1);
        chk("coincide_count", int'(bus.cyc_count), 7);
        chk("coincide_minus", int'(bus.minus_pulse), 1);
        bus.sig_in = 1'b0;
        repeat (3) tick();

        // Clear on a rise cycle: counts zeroed, no marker.
        bus.sig_in = 1'b1;
        tick();
        tick();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        chk("clr_rise_count", int'(bus.cyc_count), 0);
        chk("clr_rise_plus", int'(bus.plus_pulse), 0);
        chk("clr_rise_minus", int'(bus.minus_pulse), 0);
        chk("clr_rise_state", int'(bus.state), 0);
        bus.sig_in = 1'b0;
        repeat (3) tick();

        // Asynchronous reset mid-count.
        for (int i = 0; i < 12; i++) pulse(3, 3);
        chk("mid_count", int'(bus.cyc_count), 12);
        #2 rst = 1'b1;
        #1;
        chk("async_edge",  int'(bus.edge_pulse), 0);
        chk("async_plus",  int'(bus.plus_pulse), 0);
        chk("async_minus", int'(bus.minus_pulse), 0);
        chk("async_count", int'(bus.cyc_count), 0);
        chk("async_done",  int'(bus.done), 0);
        chk("async_terr",  int'(bus.timeout_err), 0);
        chk("async_state", int'(bus.state), 0);
        @(negedge clk);
        chk_all();
        rst = 1'b0;
        tick();
        clear_seen();
        pulse(3, 3);
        chk("post_rst_count", int'(bus.cyc_count), 1);
        chk("post_rst_minus", seen_minus, 1);
        chk("post_rst_plus", seen_plus, 0);

        // Glitches: sub-cycle pulse never sampled, then a 3-clk pulse.
        clear_seen();
        #1 bus.sig_in = 1'b1;
        #2 bus.sig_in = 1'b0;
        repeat (6) tick();
        chk("glitch_short_edges", seen_edge, 0);
        chk("glitch_short_count", int'(bus.cyc_count), 1);
        clear_seen();
        pulse(3, 6);
        chk("glitch_3clk_edges", seen_edge, 1);
        chk("glitch_3clk_count", int'(bus.cyc_count), 2);

        // Randomized traffic: busy and stalled segments with sparse pauses/clears.
        for (int s = 0; s < 12; s++) begin
            stall = ($urandom_range(0, 2) == 0);
            for (int c = 0; c < 90; c++) begin
                if (!stall && $urandom_range(0, 2) == 0) bus.sig_in = ~bus.sig_in;
                bus.enable = stall ? 1'b1 : ($urandom_range(0, 19) != 0);
                bus.clear  = ($urandom_range(0, 99) == 0);
                tick();
            end
            bus.clear = 1'b1;
            tick();
            bus.clear = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
